// File: rtl/wrf_pkt_loss_injector_if.sv
// Pipelined WR fabric link: cyc/stb/we/adr/dat/sel flow master -> slave,
// ack/stall flow slave -> master.
interface wrf_pkt_loss_injector_if #(
  parameter int g_data_width = 16
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [1:0]                adr;
  logic [g_data_width-1:0]   dat;
  logic [g_data_width/8-1:0] sel;
  logic                      ack;
  logic                      stall;

  modport master (output cyc, stb, we, adr, dat, sel, input ack, stall);
  modport slave  (input cyc, stb, we, adr, dat, sel, output ack, stall);
endinterface

// File: rtl/wrf_pkt_loss_injector.sv
// Frame-loss injector on the pipelined WR fabric. Frames are counted in
// groups of g_group_size and dropped by group mask, LFSR rate or periodic
// burst. Kept frames are forwarded combinationally; dropped frames are
// swallowed and acked locally one cycle after each strobe.
// Build option: define WRF_LOSS_STATS_EN for live saturating frame/drop
// counters; without it stat_frames_o/stat_drops_o read 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | between frames; snk_cyc rising here starts a frame and decides
// ST_PASS | frame kept: snk <-> src wired straight through
// ST_DROP | frame dropped: src held idle, snk acked from local register
module wrf_pkt_loss_injector #(
  parameter int          g_data_width = 16,
  parameter int          g_group_size = 4,
  parameter logic [15:0] g_lfsr_seed  = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  wrf_pkt_loss_injector_if.slave  snk,
  wrf_pkt_loss_injector_if.master src,
  input  logic                    cfg_en_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [g_group_size-1:0] cfg_mask_i,
  input  logic [15:0]             cfg_rate_i,
  input  logic [7:0]              cfg_burst_i,
  input  logic [7:0]              cfg_period_i,
  input  logic                    grp_clr_i,
  output logic [31:0]             stat_frames_o,
  output logic [31:0]             stat_drops_o,
  output logic [3:0]              grp_idx_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PASS = 2'd1, ST_DROP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  grp_idx_q;
  logic [7:0]  burst_cnt_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_next;
  logic [15:0] mask_ext;
  logic        clr_pend_q;
  logic        ack_q;
  logic        drop_now;
  logic        fwd;
  logic        dropping;
  logic        frame_start;
  logic        frame_end;
  logic        clr_now;

  // x^16+x^14+x^13+x^11+1, shifting right with feedback into the MSB
  assign lfsr_next   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign frame_start = (state_q == ST_IDLE) && snk.cyc;
  assign frame_end   = (state_q != ST_IDLE) && !snk.cyc;
  assign clr_now     = clr_pend_q | grp_clr_i;
  assign grp_idx_o   = grp_idx_q;

  // Drop decision for a frame starting this cycle, from live config and state.
  always_comb begin
    drop_now = 1'b0;
    mask_ext = '0;
    mask_ext[g_group_size-1:0] = cfg_mask_i;
    if (cfg_en_i) begin
      case (cfg_mode_i)
        2'd1:    drop_now = mask_ext[grp_idx_q];
        2'd2:    drop_now = (lfsr_q < cfg_rate_i);
        2'd3:    drop_now = (cfg_period_i != 8'd0) && (burst_cnt_q < cfg_burst_i);
        default: drop_now = 1'b0;
      endcase
    end
  end

  // Next state and fabric outputs; everything is forced idle while in reset
  // or while snk_cyc is low so a truncated or finished frame leaves src quiet.
  always_comb begin
    state_d   = state_q;
    fwd       = 1'b0;
    dropping  = 1'b0;
    src.cyc   = 1'b0;
    src.stb   = 1'b0;
    src.we    = 1'b0;
    src.adr   = '0;
    src.dat   = '0;
    src.sel   = '0;
    snk.ack   = 1'b0;
    snk.stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (snk.cyc) begin
          state_d  = drop_now ? ST_DROP : ST_PASS;
          fwd      = !drop_now;
          dropping = drop_now;
        end
      end
      ST_PASS: begin
        if (!snk.cyc) state_d = ST_IDLE;
        else          fwd = 1'b1;
      end
      ST_DROP: begin
        if (!snk.cyc) state_d = ST_IDLE;
        else          dropping = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fwd && !rst_i) begin
      src.cyc   = snk.cyc;
      src.stb   = snk.stb;
      src.we    = snk.we;
      src.adr   = snk.adr;
      src.dat   = snk.dat[g_data_width-1:0];
      src.sel   = snk.sel[g_data_width/8-1:0];
      snk.ack   = src.ack;
      snk.stall = src.stall;
    end
    if (dropping && !rst_i) snk.ack = ack_q;
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Group index, burst counter, LFSR, pending resync and local drop-ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grp_idx_q   <= 4'd0;
      burst_cnt_q <= 8'd0;
      lfsr_q      <= g_lfsr_seed;
      clr_pend_q  <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= snk.cyc & snk.stb;
      if (frame_start) lfsr_q <= lfsr_next;
      if (frame_end) begin
        clr_pend_q <= 1'b0;
        if (clr_now) begin
          grp_idx_q   <= 4'd0;
          burst_cnt_q <= 8'd0;
        end else begin
          grp_idx_q <= (grp_idx_q == 4'(g_group_size - 1)) ? 4'd0 : grp_idx_q + 4'd1;
          if (cfg_period_i == 8'd0 || burst_cnt_q >= cfg_period_i - 8'd1) burst_cnt_q <= 8'd0;
          else                                                             burst_cnt_q <= burst_cnt_q + 8'd1;
        end
      end else if (grp_clr_i) begin
        if (frame_start || state_q != ST_IDLE) begin
          clr_pend_q <= 1'b1;
        end else begin
          grp_idx_q   <= 4'd0;
          burst_cnt_q <= 8'd0;
        end
      end
    end
  end

`ifdef WRF_LOSS_STATS_EN
  logic [31:0] frames_q;
  logic [31:0] drops_q;

  // Saturating frame/drop counters, bumped when a frame closes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frames_q <= 32'd0;
      drops_q  <= 32'd0;
    end else if (frame_end) begin
      if (frames_q != 32'hFFFF_FFFF) frames_q <= frames_q + 32'd1;
      if (state_q == ST_DROP && drops_q != 32'hFFFF_FFFF) drops_q <= drops_q + 32'd1;
    end
  end

  assign stat_frames_o = frames_q;
  assign stat_drops_o  = drops_q;
`else
  assign stat_frames_o = 32'd0;
  assign stat_drops_o  = 32'd0;
`endif

endmodule

// File: tb/tb_wrf_pkt_loss_injector.sv
// Bench for wrf_pkt_loss_injector: directed scenarios plus a randomized run,
// all checked every cycle against a frame-level behavioural model.
module tb_wrf_pkt_loss_injector;
  localparam int          G    = 4;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef WRF_LOSS_STATS_EN
  localparam bit c_stats = 1'b1;
`else
  localparam bit c_stats = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_en_i = 1'b1;
  logic [1:0]    cfg_mode_i = 2'd0;
  logic [G-1:0]  cfg_mask_i = '0;
  logic [15:0]   cfg_rate_i = '0;
  logic [7:0]    cfg_burst_i = '0;
  logic [7:0]    cfg_period_i = '0;
  logic          grp_clr_i = 1'b0;
  logic [31:0]   stat_frames_o, stat_drops_o;
  logic [3:0]    grp_idx_o;

  wrf_pkt_loss_injector_if #(.g_data_width(16)) snk_if ();
  wrf_pkt_loss_injector_if #(.g_data_width(16)) src_if ();

  wrf_pkt_loss_injector #(.g_data_width(16), .g_group_size(G), .g_lfsr_seed(SEED)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .snk(snk_if), .src(src_if),
    .cfg_en_i(cfg_en_i), .cfg_mode_i(cfg_mode_i), .cfg_mask_i(cfg_mask_i),
    .cfg_rate_i(cfg_rate_i), .cfg_burst_i(cfg_burst_i), .cfg_period_i(cfg_period_i),
    .grp_clr_i(grp_clr_i), .stat_frames_o(stat_frames_o), .stat_drops_o(stat_drops_o),
    .grp_idx_o(grp_idx_o));

  always #5 clk_i = ~clk_i;

  int     n_chk = 0, n_pass = 0;
  bit     stall_en = 1'b0;
  int     fwd_q[$];
  int     fid = 0;
  bit     r_acc;
  bit     c_start;

  // frame-level model
  bit          m_in_frame = 0, m_drop = 0, m_pend = 0, m_prev_stb = 0;
  int          m_grp = 0, m_burst = 0;
  logic [15:0] m_lfsr = SEED;
  longint      m_frames = 0, m_drops = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic bit model_drop();
    if (!cfg_en_i) return 1'b0;
    case (cfg_mode_i)
      2'd1:    return cfg_mask_i[m_grp];
      2'd2:    return m_lfsr < cfg_rate_i;
      2'd3:    return (cfg_period_i != 0) && (m_burst < int'(cfg_burst_i));
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint fwd_pack();
    longint p = 0;
    foreach (fwd_q[i]) p = (p << 8) | longint'(fwd_q[i] + 1);
    return p;
  endfunction

  // Compare process: every cycle, outputs against the model, then advance it.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        m_in_frame = 0; m_pend = 0; m_prev_stb = 0; m_grp = 0; m_burst = 0;
        m_lfsr = SEED; m_frames = 0; m_drops = 0;
        chk("rst_src_cyc", src_if.cyc, 0);
        chk("rst_src_stb", src_if.stb, 0);
        chk("rst_snk_ack", snk_if.ack, 0);
        chk("rst_snk_stall", snk_if.stall, 0);
      end else begin
        c_start = !m_in_frame && snk_if.cyc;
        if (c_start) begin
          m_drop = model_drop();
          m_in_frame = 1;
        end
        if (snk_if.cyc && !m_drop) begin
          chk("pass_cyc", src_if.cyc, 1);
          chk("pass_stb", src_if.stb, snk_if.stb);
          chk("pass_we", src_if.we, snk_if.we);
          chk("pass_adr", src_if.adr, snk_if.adr);
          chk("pass_sel", src_if.sel, snk_if.sel);
          chk("pass_dat", src_if.dat, snk_if.dat);
          chk("pass_ack", snk_if.ack, src_if.ack);
          chk("pass_stall", snk_if.stall, src_if.stall);
        end else if (snk_if.cyc) begin
          chk("drop_cyc", src_if.cyc, 0);
          chk("drop_stb", src_if.stb, 0);
          chk("drop_stall", snk_if.stall, 0);
          chk("drop_ack", snk_if.ack, m_prev_stb);
        end else begin
          chk("idle_cyc", src_if.cyc, 0);
          chk("idle_stb", src_if.stb, 0);
          chk("idle_ack", snk_if.ack, 0);
          chk("idle_stall", snk_if.stall, 0);
        end
        if (c_start) m_lfsr = lfsr_step(m_lfsr);
        m_prev_stb = snk_if.cyc && snk_if.stb;
      end
      chk("grp_idx", grp_idx_o, m_grp);
      chk("stat_frames", stat_frames_o, c_stats ? m_frames : 0);
      chk("stat_drops", stat_drops_o, c_stats ? m_drops : 0);
      if (!rst_i) begin
        if (m_in_frame && !snk_if.cyc) begin
          m_frames++;
          if (m_drop) m_drops++;
          if (m_pend || grp_clr_i) begin
            m_grp = 0; m_burst = 0;
          end else begin
            m_grp = (m_grp + 1) % G;
            m_burst = (cfg_period_i == 0) ? 0 : (m_burst + 1) % int'(cfg_period_i);
          end
          m_pend = 0; m_in_frame = 0; m_drop = 0;
        end else if (m_in_frame && grp_clr_i) begin
          m_pend = 1;
        end else if (!m_in_frame && grp_clr_i) begin
          m_grp = 0; m_burst = 0;
        end
      end
    end
  end

  // Downstream responder: acks every accepted word one cycle later, random stalls.
  initial begin
    src_if.ack = 0; src_if.stall = 0;
    forever begin
      @(negedge clk_i);
      r_acc = src_if.cyc && src_if.stb && !src_if.stall;
      if (r_acc && src_if.dat[7:0] == 8'd0) fwd_q.push_back(int'(src_if.dat[15:8]));
      @(posedge clk_i); #1;
      src_if.ack = r_acc;
      src_if.stall = stall_en && ($urandom_range(0, 2) == 0);
    end
  end

  task automatic send_frame(input int len, input bit gaps, input int clr_at, input bit poke_cfg);
    int issued = 0, acked = 0, cyc_n = 0;
    bit hold = 0;
    @(posedge clk_i); #1;
    snk_if.cyc = 1;
    while (acked < len && cyc_n < 2000) begin
      if (!hold) begin
        if (issued < len && (!gaps || $urandom_range(0, 3) != 0)) begin
          snk_if.stb = 1;
          snk_if.we  = 1;
          snk_if.dat = {8'(fid), 8'(issued)};
          snk_if.adr = 2'(issued);
          snk_if.sel = 2'($urandom_range(1, 3));
        end else begin
          snk_if.stb = 0;
        end
      end
      grp_clr_i = (cyc_n == clr_at);
      if (poke_cfg && $urandom_range(0, 7) == 0) begin
        cfg_mask_i = G'($urandom);
        cfg_rate_i = 16'($urandom);
        cfg_mode_i = 2'($urandom);
      end
      @(negedge clk_i);
      hold = snk_if.stb && snk_if.stall;
      if (snk_if.stb && !snk_if.stall) issued++;
      if (snk_if.ack) acked++;
      @(posedge clk_i); #1;
      cyc_n++;
    end
    chk("frame_acks", acked, len);
    snk_if.cyc = 0; snk_if.stb = 0; grp_clr_i = 0;
    fid++;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1; grp_clr_i = 0;
    snk_if.cyc = 0; snk_if.stb = 0; snk_if.we = 0; snk_if.adr = 0; snk_if.dat = 0; snk_if.sel = 0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 0;
    fwd_q.delete();
    fid = 0;
  endtask

  task automatic settle();
    repeat (2) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    snk_if.cyc = 0; snk_if.stb = 0; snk_if.we = 0; snk_if.adr = 0; snk_if.dat = 0; snk_if.sel = 0;
    do_reset();
    @(negedge clk_i);
    chk("reset_grp", grp_idx_o, 0);
    chk("reset_frames", stat_frames_o, 0);
    chk("reset_src_cyc", src_if.cyc, 0);

    // 1: group mask 0110 over 8 long frames
    do_reset();
    cfg_en_i = 1; cfg_mode_i = 2'd1; cfg_mask_i = 4'b0110; stall_en = 0;
    repeat (8) send_frame(250, 0, -1, 0);
    settle();
    chk("t1_fwd_cnt", fwd_q.size(), 4);
    chk("t1_fwd_ids", fwd_pack(), 64'h01040508);
    chk("t1_drops", stat_drops_o, c_stats ? 4 : 0);
    chk("t1_grp", grp_idx_o, 0);

    // 2: disabled, everything forwarded under random stalls
    do_reset();
    cfg_en_i = 0; cfg_mode_i = 2'd1; cfg_mask_i = 4'b1111; stall_en = 1;
    repeat (5) send_frame(20, 1, -1, 0);
    settle();
    chk("t2_fwd_cnt", fwd_q.size(), 5);
    chk("t2_fwd_ids", fwd_pack(), 64'h0102030405);
    chk("t2_drops", stat_drops_o, 0);
    chk("t2_frames", stat_frames_o, c_stats ? 5 : 0);

    // 3: burst 2 of every 5
    do_reset();
    cfg_en_i = 1; cfg_mode_i = 2'd3; cfg_burst_i = 8'd2; cfg_period_i = 8'd5; stall_en = 0;
    repeat (10) send_frame(4, 1, -1, 0);
    settle();
    chk("t3_fwd_cnt", fwd_q.size(), 6);
    chk("t3_fwd_ids", fwd_pack(), 64'h030405_08090A);
    chk("t3_drops", stat_drops_o, c_stats ? 4 : 0);
    chk("t3_grp", grp_idx_o, 2);

    // 4: random mode at the rate extremes
    do_reset();
    cfg_mode_i = 2'd2; cfg_rate_i = 16'h0000;
    repeat (100) send_frame(2, 0, -1, 0);
    settle();
    chk("t4_rate0_fwd", fwd_q.size(), 100);
    do_reset();
    cfg_rate_i = 16'hFFFF;
    repeat (100) send_frame(2, 0, -1, 0);
    settle();
    chk("t4_rateff_fwd", fwd_q.size(), 0);
    chk("t4_rateff_drops", stat_drops_o, c_stats ? 100 : 0);

    // 5: reset in the middle of a forwarded frame
    do_reset();
    cfg_mode_i = 2'd1; cfg_mask_i = 4'b0001; cfg_period_i = 8'd0;
    repeat (2) send_frame(4, 0, -1, 0);
    @(posedge clk_i); #1;
    snk_if.cyc = 1; snk_if.stb = 1; snk_if.we = 1; snk_if.sel = 2'b11;
    for (int i = 0; i < 3; i++) begin
      snk_if.dat = {8'd2, 8'(i)};
      snk_if.adr = 2'(i);
      @(posedge clk_i); #1;
    end
    rst_i = 1;
    @(negedge clk_i);
    chk("t5_src_cyc_in_rst", src_if.cyc, 0);
    @(posedge clk_i); #1;
    rst_i = 0; snk_if.cyc = 0; snk_if.stb = 0;
    @(negedge clk_i);
    chk("t5_grp_after_rst", grp_idx_o, 0);
    fid = 3;
    send_frame(4, 0, -1, 0);
    settle();
    chk("t5_fwd_ids", fwd_pack(), 64'h0203);
    chk("t5_grp", grp_idx_o, 1);

    // 6: resync pulse inside frame 1
    do_reset();
    cfg_mode_i = 2'd1; cfg_mask_i = 4'b0001;
    send_frame(4, 0, -1, 0);
    send_frame(4, 0, 2, 0);
    send_frame(4, 0, -1, 0);
    send_frame(4, 0, -1, 0);
    settle();
    chk("t6_fwd_ids", fwd_pack(), 64'h0204);
    chk("t6_grp", grp_idx_o, 2);
    chk("t6_frames", stat_frames_o, c_stats ? 4 : 0);
    chk("t6_drops", stat_drops_o, c_stats ? 2 : 0);

    // randomized run, checked by the model every cycle
    do_reset();
    cfg_period_i = 8'($urandom_range(0, 6));
    stall_en = 1;
    repeat (60) begin
      cfg_en_i    = ($urandom_range(0, 7) != 0);
      cfg_mode_i  = 2'($urandom);
      cfg_mask_i  = G'($urandom);
      cfg_rate_i  = 16'($urandom);
      cfg_burst_i = 8'($urandom_range(0, 7));
      send_frame(int'($urandom_range(1, 6)), 1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1, 1);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk_i); #1; grp_clr_i = 1;
        @(posedge clk_i); #1; grp_clr_i = 0;
      end
    end
    settle();
    chk("rand_frames", stat_frames_o, c_stats ? 60 : 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
